// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: byte FIFO behind a valid/ready port feeding an
// 8-bit serializer with optional parity and one or two stop bits.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int FIFO_DEPTH   = 16,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    input  logic [7:0]                    in_data,
    output logic                          in_ready,
    output logic                          tx,
    output logic                          tx_busy,
    output logic                          tx_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BIT_LAST   = CW'(CLKS_PER_BIT - 1);
    localparam logic [AW:0]   FULL_COUNT = (AW+1)'(FIFO_DEPTH);
    localparam logic          PAR_INIT   = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [7:0]    head;
    logic          fifo_nonempty;
    logic          push;
    logic          pop;

    state_t        state;
    logic [CW-1:0] bit_cnt;
    logic [2:0]    bit_idx;
    logic          stop_idx;
    logic [7:0]    shreg;
    logic          par_bit;
    logic          bit_end;
    logic          stop_end;

    assign fifo_nonempty = (count != '0);
    assign in_ready      = (count != FULL_COUNT);
    assign push          = in_valid && in_ready;
    assign head          = mem[rd_ptr];
    assign fifo_count    = count;

    assign bit_end  = (bit_cnt == BIT_LAST);
    assign stop_end = bit_end && ((STOP_BITS == 1) || stop_idx);

    // The serializer takes a byte either to start from idle or to chain the
    // next frame directly off the final stop cycle.
    assign pop = fifo_nonempty &&
                 ((state == S_IDLE) || ((state == S_STOP) && stop_end));

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= in_data;
    end

    // tx is registered from the current state, so the line trails the state
    // by one cycle; tx_done is timed to coincide with the last stop cycle on tx.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            bit_cnt  <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            shreg    <= '0;
            par_bit  <= 1'b0;
            tx       <= 1'b1;
            tx_busy  <= 1'b0;
            tx_done  <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            if (state != S_IDLE)
                bit_cnt <= bit_end ? '0 : bit_cnt + CW'(1);

            case (state)
                S_IDLE: begin
                    tx <= 1'b1;
                    if (fifo_nonempty) begin
                        shreg   <= head;
                        par_bit <= (^head) ^ PAR_INIT;
                        bit_cnt <= '0;
                        tx_busy <= 1'b1;
                        state   <= S_START;
                    end
                end
                S_START: begin
                    tx <= 1'b0;
                    if (bit_end) begin
                        bit_idx <= '0;
                        state   <= S_DATA;
                    end
                end
                S_DATA: begin
                    tx <= shreg[0];
                    if (bit_end) begin
                        shreg   <= {1'b0, shreg[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            stop_idx <= 1'b0;
                            state    <= (PARITY_EN != 0) ? S_PARITY : S_STOP;
                        end
                    end
                end
                S_PARITY: begin
                    tx <= par_bit;
                    if (bit_end) begin
                        stop_idx <= 1'b0;
                        state    <= S_STOP;
                    end
                end
                S_STOP: begin
                    tx <= 1'b1;
                    if (stop_end) begin
                        tx_done <= 1'b1;
                        if (fifo_nonempty) begin
                            shreg   <= head;
                            par_bit <= (^head) ^ PAR_INIT;
                            state   <= S_START;
                        end else begin
                            tx_busy <= 1'b0;
                            state   <= S_IDLE;
                        end
                    end else if (bit_end) begin
                        stop_idx <= 1'b1;
                    end
                end
                default: begin
                    tx      <= 1'b1;
                    tx_busy <= 1'b0;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: three instances (plain, even parity + 2 stop, odd
// parity) share one stimulus; per-instance line monitors check against a byte queue.
module tb_uart_tx_fifo;

    localparam int C     = 4;
    localparam int DEPTH = 4;
    localparam int CNTW  = $clog2(DEPTH) + 1;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;

    wire [2:0]      tx_w;
    wire [2:0]      rdy_w;
    wire [2:0]      busy_w;
    wire [2:0]      done_w;
    wire [CNTW-1:0] cnt_w [3];

    int num_vec = 0;
    int num_err = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        num_vec++;
        if (act != exp) begin
            num_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic frame_bit(input logic [7:0] d, input int idx,
                                       input int pen, input int podd);
        if (idx == 0)
            return 1'b0;
        if (idx <= 8)
            return d[idx-1];
        if (idx == 9 && pen != 0)
            return (^d) ^ (podd != 0);
        return 1'b1;
    endfunction

    genvar g;
    for (g = 0; g < 3; g++) begin : g_dut
        localparam int PEN   = (g == 0) ? 0 : 1;
        localparam int PODD  = (g == 2) ? 1 : 0;
        localparam int NSTOP = (g == 1) ? 2 : 1;
        localparam int FLEN  = (9 + PEN + NSTOP) * C;

        uart_tx_fifo #(
            .CLKS_PER_BIT (C),
            .FIFO_DEPTH   (DEPTH),
            .PARITY_EN    (PEN),
            .PARITY_ODD   (PODD),
            .STOP_BITS    (NSTOP)
        ) dut (
            .clk        (clk),
            .rst        (rst),
            .in_valid   (in_valid),
            .in_data    (in_data),
            .in_ready   (rdy_w[g]),
            .tx         (tx_w[g]),
            .tx_busy    (busy_w[g]),
            .tx_done    (done_w[g]),
            .fifo_count (cnt_w[g])
        );

        logic [7:0] q [$];
        logic [7:0] cur;
        bit         in_fr;
        int         cnt;

        initial begin
            in_fr = 1'b0;
            cnt   = 0;
            cur   = '0;
        end

        // Bytes are queued at the handshake and checked bit by bit on the line.
        always @(negedge clk) begin
            if (rst) begin
                q.delete();
                in_fr <= 1'b0;
                cnt   <= 0;
            end else begin
                if (in_valid && rdy_w[g])
                    q.push_back(in_data);
                if (!in_fr) begin
                    chk($sformatf("idle_done[%0d]", g), int'(done_w[g]), 0);
                    if (!tx_w[g]) begin
                        if (q.size() == 0) begin
                            chk($sformatf("unexpected_frame[%0d]", g), 1, 0);
                        end else begin
                            cur   <= q.pop_front();
                            in_fr <= 1'b1;
                            cnt   <= 1;
                            chk($sformatf("start_busy[%0d]", g), int'(busy_w[g]), 1);
                        end
                    end
                end else begin
                    chk($sformatf("tx[%0d] byte %02h bit %0d", g, cur, cnt / C),
                        int'(tx_w[g]), int'(frame_bit(cur, cnt / C, PEN, PODD)));
                    chk($sformatf("done[%0d] cyc %0d", g, cnt),
                        int'(done_w[g]), int'(cnt == FLEN - 1));
                    if (cnt < FLEN - 1)
                        chk($sformatf("busy[%0d] cyc %0d", g, cnt), int'(busy_w[g]), 1);
                    if (cnt == FLEN - 1)
                        in_fr <= 1'b0;
                    else
                        cnt <= cnt + 1;
                end
            end
        end
    end

    bit meas;
    int busy_cnt [3];
    int done_cnt [3];
    int acc_cnt  [3];
    int max_cnt  [3];

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!meas) begin
                busy_cnt[i] <= 0;
                done_cnt[i] <= 0;
                acc_cnt[i]  <= 0;
                max_cnt[i]  <= 0;
            end else begin
                if (busy_w[i])
                    busy_cnt[i] <= busy_cnt[i] + 1;
                if (done_w[i])
                    done_cnt[i] <= done_cnt[i] + 1;
                if (in_valid && rdy_w[i] && !rst)
                    acc_cnt[i] <= acc_cnt[i] + 1;
                if (int'(cnt_w[i]) > max_cnt[i])
                    max_cnt[i] <= int'(cnt_w[i]);
            end
        end
    end

    // Called half a cycle... rather #1 after a rising edge; returns at the
    // same phase one edge later, with the byte accepted on that edge.
    task automatic drive(input logic [7:0] d);
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy_w != 3'b000 || tx_w != 3'b111 || cnt_w[0] != '0 ||
                cnt_w[1] != '0 || cnt_w[2] != '0) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("idle_reached", int'(n < 2000), 1);
        repeat (3) @(negedge clk);
    endtask

    task automatic chk_reset_outputs(input string tag);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s_tx[%0d]", tag, i), int'(tx_w[i]), 1);
            chk($sformatf("%s_busy[%0d]", tag, i), int'(busy_w[i]), 0);
            chk($sformatf("%s_done[%0d]", tag, i), int'(done_w[i]), 0);
            chk($sformatf("%s_count[%0d]", tag, i), int'(cnt_w[i]), 0);
            chk($sformatf("%s_ready[%0d]", tag, i), int'(rdy_w[i]), 1);
        end
    endtask

    typedef struct {
        logic [7:0] data;
        logic       par_even;
        logic       par_odd;
    } vec_t;

    vec_t vecs [6];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  k;
        int  done_at [3];
        int  cyc;
        bit  hs;
        bit  all_high;
        int  exp_len [3];

        vecs[0] = '{8'hA5, 1'b0, 1'b1};
        vecs[1] = '{8'h07, 1'b1, 1'b0};
        vecs[2] = '{8'h00, 1'b0, 1'b1};
        vecs[3] = '{8'hFF, 1'b0, 1'b1};
        vecs[4] = '{8'h80, 1'b1, 1'b0};
        vecs[5] = '{8'h3C, 1'b0, 1'b1};
        exp_len = '{39, 47, 43};

        meas     = 1'b0;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("in_reset");
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_reset_outputs("after_reset");

        // Single frames from idle: latency, parity bit, frame length.
        for (int v = 0; v < 6; v++) begin
            @(posedge clk);
            #1;
            drive(vecs[v].data);
            in_valid = 1'b0;
            @(negedge clk);
            chk("cnt_after_accept", int'(cnt_w[0]), 1);
            chk("tx_high_n1", int'(tx_w[0]), 1);
            @(negedge clk);
            chk("cnt_after_pop", int'(cnt_w[0]), 0);
            chk("tx_high_n2", int'(tx_w[0]), 1);
            chk("busy_n2", int'(busy_w[0]), 1);
            @(negedge clk);
            chk("start_low_n3", int'(tx_w[0]), 0);
            repeat (38) @(negedge clk);
            chk($sformatf("parity_even %02h", vecs[v].data), int'(tx_w[1]), int'(vecs[v].par_even));
            chk($sformatf("parity_odd %02h", vecs[v].data), int'(tx_w[2]), int'(vecs[v].par_odd));
            done_at = '{-1, -1, -1};
            for (cyc = 39; cyc <= 50; cyc++) begin
                @(negedge clk);
                for (int i = 0; i < 3; i++)
                    if (done_w[i] && done_at[i] < 0)
                        done_at[i] = cyc;
            end
            for (int i = 0; i < 3; i++)
                chk($sformatf("frame_len[%0d] %02h", i, vecs[v].data), done_at[i], exp_len[i]);
            wait_idle();
        end

        // Back-to-back frames: no idle gap, busy held, queue depth peaks at 2.
        @(posedge clk);
        #1 meas = 1'b1;
        drive(8'h01);
        drive(8'h02);
        drive(8'h03);
        in_valid = 1'b0;
        wait_idle();
        chk("b2b_busy_cycles", busy_cnt[0], 120);
        chk("b2b_max_count", max_cnt[0], 2);
        for (int i = 0; i < 3; i++)
            chk($sformatf("b2b_done[%0d]", i), done_cnt[i], 3);
        @(posedge clk);
        #1 meas = 1'b0;

        // Two stop bits between chained frames.
        @(posedge clk);
        #1 meas = 1'b1;
        drive(8'h00);
        drive(8'hFF);
        in_valid = 1'b0;
        wait_idle();
        chk("stop2_busy_cycles", busy_cnt[1], 96);
        chk("stop2_done", done_cnt[1], 2);
        chk("stop1_busy_cycles", busy_cnt[0], 80);
        @(posedge clk);
        #1 meas = 1'b0;

        // Full FIFO: hold valid, advance data only when instance 0 accepts.
        @(posedge clk);
        #1;
        meas     = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h10;
        for (int i = 0; i <= 45; i++) begin
            @(negedge clk);
            hs = rdy_w[0];
            if (i == 10) begin
                for (int j = 0; j < 3; j++) begin
                    chk($sformatf("full_ready[%0d]", j), int'(rdy_w[j]), 0);
                    chk($sformatf("full_count[%0d]", j), int'(cnt_w[j]), 4);
                end
            end
            if (i == 41) begin
                chk("full_pop_cycle_ready", int'(rdy_w[0]), 0);
                chk("full_pop_cycle_count", int'(cnt_w[0]), 4);
            end
            if (i == 42) begin
                chk("freed_ready", int'(rdy_w[0]), 1);
                chk("freed_count", int'(cnt_w[0]), 3);
            end
            if (i == 43) begin
                chk("refull_ready", int'(rdy_w[0]), 0);
                chk("refull_count", int'(cnt_w[0]), 4);
            end
            @(posedge clk);
            #1;
            if (hs)
                in_data = in_data + 8'd1;
        end
        in_valid = 1'b0;
        wait_idle();
        chk("full_accepts[0]", acc_cnt[0], 6);
        chk("full_accepts[1]", acc_cnt[1], 5);
        chk("full_accepts[2]", acc_cnt[2], 5);
        @(posedge clk);
        #1 meas = 1'b0;

        // Reset during data bit 3 with two bytes queued.
        @(posedge clk);
        #1 meas = 1'b1;
        drive(8'h5A);
        drive(8'hC3);
        drive(8'h96);
        in_valid = 1'b0;
        repeat (17) @(posedge clk);
        #1;
        chk("pre_reset_count", int'(cnt_w[0]), 2);
        chk("pre_reset_busy", int'(busy_w[0]), 1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_reset_outputs("mid_reset");
        all_high = 1'b1;
        repeat (60) begin
            @(negedge clk);
            if (tx_w != 3'b111 || busy_w != 3'b000)
                all_high = 1'b0;
        end
        chk("line_idle_after_reset", int'(all_high), 1);
        for (int i = 0; i < 3; i++)
            chk($sformatf("reset_no_done[%0d]", i), done_cnt[i], 0);
        @(posedge clk);
        #1 meas = 1'b0;

        // Normal operation resumes after the mid-frame reset.
        @(posedge clk);
        #1 meas = 1'b1;
        drive(8'hE7);
        in_valid = 1'b0;
        wait_idle();
        for (int i = 0; i < 3; i++)
            chk($sformatf("post_reset_done[%0d]", i), done_cnt[i], 1);
        @(posedge clk);
        #1 meas = 1'b0;

        for (int i = 0; i < 3; i++)
            chk($sformatf("queue_drained[%0d]", i), int'(cnt_w[i]), 0);

        $display("== %0d vectors applied, %0d miscompares ==", num_vec, num_err);
        $finish;
    end

endmodule
